// File: rtl/key_debouncer_if.sv
// Key channel bundle: raw active-low key inputs and conditioned level/event outputs.
interface key_debouncer_if #(
  parameter int unsigned NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] keys_n;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output keys_n,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_repeat
  );

  modport slave (
    input  keys_n,
    output key_state,
    output key_press,
    output key_release,
    output key_long,
    output key_repeat
  );
endinterface

// File: rtl/key_debouncer.sv
// Push-button conditioner: per-key synchroniser, debounce FSM, press/release/long strobes.
// Define KEY_REPEAT_EN to add periodic key_repeat strobes while a key stays long-held.
module key_debouncer #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input logic            clock,
  input logic            nReset,
  key_debouncer_if.slave bus
);

  localparam logic [31:0] DebLast  = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LongLast = 32'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [31:0] RepLast  = 32'(REPEAT_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : gen_param_check
    $error("key_debouncer: cycle parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StPressed,
    StLongHeld,
    StDebRelease
  } state_e;

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync_q;
  logic [NUM_KEYS-1:0] key_state_vec;
  logic [NUM_KEYS-1:0] key_press_vec;
  logic [NUM_KEYS-1:0] key_release_vec;
  logic [NUM_KEYS-1:0] key_long_vec;
  logic [NUM_KEYS-1:0] key_repeat_vec;

  // Reset loads "released" so a key held through reset is seen as a fresh press.
  always_ff @(posedge clock) begin
    if (!nReset) begin
      sync1_q <= '1;
      sync_q  <= '1;
    end else begin
      sync1_q <= bus.keys_n;
      sync_q  <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : gen_key
    state_e      state_q;
    logic [31:0] deb_cnt_q;
    logic [31:0] hold_cnt_q;
    logic        long_done_q;
    logic        key_state_q;
    logic        press_q;
    logic        release_q;
    logic        long_q;
    logic        s;

    assign s = sync_q[i];

`ifdef KEY_REPEAT_EN
    logic [31:0] rep_cnt_q;
    logic        repeat_q;

    always_ff @(posedge clock) begin
      if (!nReset) begin
        rep_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        case (state_q)
          StPressed: begin
            if (!s && hold_cnt_q == LongLast) rep_cnt_q <= '0;
          end
          StLongHeld: begin
            if (!s) begin
              if (rep_cnt_q == RepLast) begin
                repeat_q  <= 1'b1;
                rep_cnt_q <= '0;
              end else begin
                rep_cnt_q <= rep_cnt_q + 32'd1;
              end
            end
          end
          StDebRelease: begin
            if (s && deb_cnt_q == DebLast) rep_cnt_q <= '0;
          end
          default: ;
        endcase
      end
    end

    assign key_repeat_vec[i] = repeat_q;
`else
    assign key_repeat_vec[i] = 1'b0;
`endif

    always_ff @(posedge clock) begin
      if (!nReset) begin
        state_q     <= StIdle;
        deb_cnt_q   <= '0;
        hold_cnt_q  <= '0;
        long_done_q <= 1'b0;
        key_state_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          StIdle: begin
            if (!s) begin
              state_q   <= StDebPress;
              deb_cnt_q <= '0;
            end
          end
          StDebPress: begin
            if (s) begin
              state_q   <= StIdle;
              deb_cnt_q <= '0;
            end else if (deb_cnt_q == DebLast) begin
              state_q     <= StPressed;
              press_q     <= 1'b1;
              key_state_q <= 1'b1;
              hold_cnt_q  <= '0;
            end else begin
              deb_cnt_q <= deb_cnt_q + 32'd1;
            end
          end
          StPressed: begin
            if (s) begin
              state_q   <= StDebRelease;
              deb_cnt_q <= '0;
            end else if (hold_cnt_q == LongLast) begin
              state_q     <= StLongHeld;
              long_q      <= 1'b1;
              long_done_q <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q + 32'd1;
            end
          end
          StLongHeld: begin
            if (s) begin
              state_q   <= StDebRelease;
              deb_cnt_q <= '0;
            end
          end
          StDebRelease: begin
            // A release bounce resumes the hold with hold_cnt_q untouched.
            if (!s) begin
              state_q <= long_done_q ? StLongHeld : StPressed;
            end else if (deb_cnt_q == DebLast) begin
              state_q     <= StIdle;
              release_q   <= 1'b1;
              key_state_q <= 1'b0;
              long_done_q <= 1'b0;
              hold_cnt_q  <= '0;
            end else begin
              deb_cnt_q <= deb_cnt_q + 32'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign key_state_vec[i]   = key_state_q;
    assign key_press_vec[i]   = press_q;
    assign key_release_vec[i] = release_q;
    assign key_long_vec[i]    = long_q;
  end

  assign bus.key_state   = key_state_vec;
  assign bus.key_press   = key_press_vec;
  assign bus.key_release = key_release_vec;
  assign bus.key_long    = key_long_vec;
  assign bus.key_repeat  = key_repeat_vec;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: run-length reference model feeds a per-cycle expectation queue
// that a negedge monitor drains and compares against the DUT outputs.
module tb_key_debouncer;
  localparam int unsigned NK   = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int unsigned REP  = 8;

  typedef struct packed {
    logic [NK-1:0] st;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] lg;
    logic [NK-1:0] rp;
  } obs_t;

  logic clock  = 1'b0;
  logic nReset = 1'b0;

  always #5 clock = ~clock;

  key_debouncer_if #(.NUM_KEYS(NK)) bus ();

  key_debouncer #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clock (clock),
    .nReset(nReset),
    .bus   (bus)
  );

  obs_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: the key is judged from run lengths of the twice-delayed raw input.
  logic        m_s1[NK], m_s2[NK], m_prev[NK], m_pressed[NK], m_long[NK];
  int unsigned m_zrun[NK], m_orun[NK], m_hold[NK], m_rep[NK];

  task automatic model_edge(input logic [NK-1:0] k, input logic r);
    obs_t e;
    e = '0;
    for (int i = 0; i < NK; i++) begin
      if (!r) begin
        m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_prev[i] = 1'b1;
        m_pressed[i] = 1'b0; m_long[i] = 1'b0;
        m_zrun[i] = 0; m_orun[i] = 0; m_hold[i] = 0; m_rep[i] = 0;
      end else begin
        logic obs;
        obs     = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = k[i];
        if (obs) begin
          m_orun[i]++;
          m_zrun[i] = 0;
        end else begin
          m_zrun[i]++;
          m_orun[i] = 0;
        end
        if (!m_pressed[i]) begin
          if (m_zrun[i] == DEB + 1) begin
            m_pressed[i] = 1'b1; e.pr[i] = 1'b1; m_hold[i] = 0; m_long[i] = 1'b0;
          end
        end else if (obs) begin
          if (m_orun[i] == DEB + 1) begin
            m_pressed[i] = 1'b0; e.rl[i] = 1'b1; m_long[i] = 1'b0;
          end
        end else if (!m_prev[i]) begin
          // Held-low cycle not directly following a release bounce.
          if (!m_long[i]) begin
            m_hold[i]++;
            if (m_hold[i] == LONG) begin
              e.lg[i] = 1'b1; m_long[i] = 1'b1; m_rep[i] = 0;
            end
          end else begin
            m_rep[i]++;
            if (m_rep[i] == REP) begin
              m_rep[i] = 0;
`ifdef KEY_REPEAT_EN
              e.rp[i] = 1'b1;
`endif
            end
          end
        end
        m_prev[i] = obs;
      end
      e.st[i] = m_pressed[i];
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NK-1:0] k, input logic r);
    bus.keys_n = k;
    nReset     = r;
    @(posedge clock);
    model_edge(k, r);
    #1;
  endtask

  task automatic hold(input logic [NK-1:0] k, input int n);
    for (int c = 0; c < n; c++) step(k, 1'b1);
  endtask

  always @(negedge clock) begin
    obs_t e;
    obs_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{st: bus.key_state, pr: bus.key_press, rl: bus.key_release,
            lg: bus.key_long, rp: bus.key_repeat};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t got st=%b pr=%b rl=%b lg=%b rp=%b want st=%b pr=%b rl=%b lg=%b rp=%b",
                 $time, g.st, g.pr, g.rl, g.lg, g.rp, e.st, e.pr, e.rl, e.lg, e.rp);
      end
    end
  end

  int unsigned   run[NK];
  logic [NK-1:0] rk;

  initial begin
    bus.keys_n = '1;
    for (int c = 0; c < 3; c++) step(2'b11, 1'b0);

    // Clean press and release of key 0.
    hold(2'b10, 12);
    hold(2'b11, 10);

    // Bounce rejection, then a minimal accepted press.
    hold(2'b10, 3); hold(2'b11, 1); hold(2'b10, 3); hold(2'b11, 8);
    hold(2'b10, 5); hold(2'b11, 10);

    // Long press, release glitch, final release.
    hold(2'b10, 36);
    hold(2'b11, 3); hold(2'b10, 2); hold(2'b11, 12);

    // Simultaneous keys, release key 1 only.
    hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10);

    // Reset mid-debounce, key held through reset.
    hold(2'b10, 4);
    step(2'b10, 1'b0);
    hold(2'b10, 10);
    // Reset while long-held.
    hold(2'b10, 25);
    step(2'b10, 1'b0);
    hold(2'b11, 10);

    // Extended hold for repeat strobes.
    hold(2'b10, 60); hold(2'b11, 10);

    // Randomised traffic on both keys.
    rk = '1;
    for (int i = 0; i < NK; i++) run[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (run[i] == 0) begin
          rk[i]  = ~rk[i];
          run[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 70) : $urandom_range(1, 7);
        end
        run[i]--;
      end
      step(rk, $urandom_range(0, 299) != 0);
    end
    hold(2'b11, 10);

    @(negedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
